dcpu_ram_arbiter: RTL
=====================

// Module: dcpu_ram_arbiter
// PURPOSE
//  Shares the single-port 64K x 16 system RAM between the DCPU core and N_DEV hardware devices
//  (display scan-out, floppy DMA, ...). One RAM access per CORE_CLK cycle. CPU has default priority.
//  Devices are round-robin among themselves, with a starvation guard and optional locked bursts.
//  Sits between the core/device memory ports and the RAM macro.
// PARAMETERS
//  N_DEV        2   number of device ports (1..8)
//  STARVE_LIMIT 8   cycles a device may wait while CPU wins before the device is forced through
//  BURST_MAX    16  max consecutive grants to one locked device before a forced 1-cycle release
// PORTS
//  CORE_CLK    in   1         clock; all state on posedge
//  RESET       in   1         asynchronous, active-high
//  cpu_req     in   1         CPU access request; hold with cpu_we/addr/wdata stable until cpu_gnt
//  cpu_we      in   1         1=write, 0=read
//  cpu_addr    in   16        word address
//  cpu_wdata   in   16        write data
//  cpu_gnt     out  1         access issued to RAM this cycle
//  cpu_rvalid  out  1         read data valid on rdata (cycle after a read grant)
//  dev_req     in   N_DEV     per-device request; same hold rule as cpu_req
//  dev_lock    in   N_DEV     keep ownership for consecutive accesses while asserted with req
//  dev_we      in   N_DEV     per-device write enable
//  dev_addr    in   16*N_DEV  packed addresses, device i at [16i+15:16i]
//  dev_wdata   in   16*N_DEV  packed write data
//  dev_gnt     out  N_DEV     one-hot (or zero) grant
//  dev_rvalid  out  N_DEV     one-hot read-data-valid
//  rdata       out  16        shared read data = ram_rdata, qualified by *_rvalid
//  ram_en      out  1         RAM access enable
//  ram_we      out  1         RAM write enable
//  ram_addr    out  16        RAM address
//  ram_wdata   out  16        RAM write data
//  ram_rdata   in   16        RAM read data, 1-cycle synchronous latency
// BEHAVIOUR
//  - Reset: all gnt/rvalid=0, ram_en=ram_we=0, ram_addr=ram_wdata=0, rr_ptr=0, starve_cnt=0,
//    burst_cnt=0, state=ARB. Grants forced 0 while RESET high; in-flight rvalid discarded.
//  - Grant is combinational from registered state + current requests; at most one grant per cycle.
//    Winner's we/addr/wdata muxed to ram_* same cycle; ram_en=|grants; no grant -> ram_en=ram_we=0.
//  - Read granted in cycle t -> winner's rvalid=1 in t+1 (registered one-hot owner tag), rdata valid.
//    Writes produce no rvalid. Back-to-back grants to the same port allowed (throughput 1/cycle).
//  - Priority in ARB: (1) lowest-index device at/after rr_ptr if starve_cnt==STARVE_LIMIT;
//    (2) else CPU if cpu_req; (3) else round-robin device from rr_ptr.
//  - rr_ptr <= (granted device + 1) mod N_DEV on every device grant; unchanged otherwise.
//  - starve_cnt: +1 each cycle |dev_req && no device granted, saturating at STARVE_LIMIT;
//    cleared on any device grant or when no device requests.
//  - FSM ARB -> LOCKED(owner) when device granted with dev_lock[owner]=1; burst_cnt<=1.
//    LOCKED: owner granted whenever dev_req[owner]; CPU and others held off; burst_cnt+1 per grant.
//    LOCKED -> ARB when dev_lock[owner]=0 or dev_req[owner]=0 (no grant that cycle), or when
//    burst_cnt==BURST_MAX (that cycle: no owner grant, CPU granted if requesting, rr_ptr=owner+1).
//  - CPU always wins the forced-release cycle even if starve_cnt is saturated.
//  - Simultaneous cpu_req and saturated starvation: device wins, CPU waits exactly one cycle.
//  - Address/data 16-bit, no arithmetic on addresses; wrap at 0xFFFF is the RAM's concern.
//  - Reset mid-burst returns to ARB; no partial rvalid emitted after RESET deasserts.
// STRUCTURE
//  - dcpu_pkg: ADDR_W=16, DATA_W=16, typedef enum {ARB, LOCKED} arb_state_t.
//  - Sub-module dcpu_rr_pick: N_DEV-wide round-robin priority encoder (req, ptr -> one-hot, index, any).
//  - Top: FSM, starve/burst counters, output mux, rvalid owner register.
// TESTING
//  1. cpu_req read 0x1234 with RAM preloaded 0xBEEF -> cpu_gnt cycle t, cpu_rvalid+rdata=0xBEEF t+1.
//  2. cpu_req held + dev_req[0] held, STARVE_LIMIT=8 -> CPU 8 grants, dev0 granted on 9th cycle, repeat.
//  3. dev_req=2'b11 no CPU -> grants alternate dev0,dev1,dev0,... ; rr_ptr toggles each grant.
//  4. dev1 lock+req for 20 cycles, cpu_req held, BURST_MAX=16 -> 16 dev1 grants, 1 CPU grant, relock.
//  5. RESET pulsed 1 cycle after a dev0 read grant -> no dev_rvalid, all outputs 0, rr_ptr=0.
//  6. CPU write 0x0042 to 0x8000 then read -> ram_we=1 once, read returns 0x0042, no rvalid on write.

Source files
------------

// File: rtl/dcpu_pkg.sv
// dcpu_pkg: shared bus widths, arbiter state type and an index-width helper.
package dcpu_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    typedef enum logic {ARB, LOCKED} arb_state_t;

    // Bits needed to hold a device index; a single device still gets one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dcpu_rr_pick.sv
// dcpu_rr_pick: round-robin priority encoder, first requester at or after ptr wins.
//  req  in  N   request vector
//  ptr  in  IW  starting index of the search
//  gnt  out N   one-hot winner (zero when nobody requests)
//  idx  out IW  winner index
//  any  out 1   at least one request present
module dcpu_rr_pick
    import dcpu_pkg::*;
#(
    parameter  int N  = 2,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    assign any = |req;

    // Scan from the farthest offset down so the nearest requester overwrites the rest.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                gnt = N'(1) << ((int'(ptr) + k) % N);
                idx = IW'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/dcpu_ram_arbiter.sv
// dcpu_ram_arbiter: shares one single-port RAM between the CPU and N_DEV devices.
//  CORE_CLK/RESET                 clock, asynchronous active-high reset
//  cpu_req/we/addr/wdata          CPU request port, held until cpu_gnt
//  cpu_gnt/cpu_rvalid             CPU grant this cycle, read data valid next cycle
//  dev_req/lock/we/addr/wdata     packed device request ports (device i at [16i+15:16i])
//  dev_gnt/dev_rvalid             one-hot device grant and read-data-valid
//  rdata                          shared read data, qualified by the rvalids
//  ram_en/we/addr/wdata/rdata     RAM macro port, read latency one cycle
module dcpu_ram_arbiter
    import dcpu_pkg::*;
#(
    parameter int N_DEV        = 2,
    parameter int STARVE_LIMIT = 8,
    parameter int BURST_MAX    = 16
) (
    input  logic                      CORE_CLK,
    input  logic                      RESET,
    input  logic                      cpu_req,
    input  logic                      cpu_we,
    input  logic [ADDR_W-1:0]         cpu_addr,
    input  logic [DATA_W-1:0]         cpu_wdata,
    output logic                      cpu_gnt,
    output logic                      cpu_rvalid,
    input  logic [N_DEV-1:0]          dev_req,
    input  logic [N_DEV-1:0]          dev_lock,
    input  logic [N_DEV-1:0]          dev_we,
    input  logic [ADDR_W*N_DEV-1:0]   dev_addr,
    input  logic [DATA_W*N_DEV-1:0]   dev_wdata,
    output logic [N_DEV-1:0]          dev_gnt,
    output logic [N_DEV-1:0]          dev_rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      ram_en,
    output logic                      ram_we,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic [DATA_W-1:0]         ram_wdata,
    input  logic [DATA_W-1:0]         ram_rdata
);

    localparam int IW = idx_w(N_DEV);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int BW = $clog2(BURST_MAX + 1);

    arb_state_t       state;
    logic [IW-1:0]    rr_ptr, owner, pick_idx, nxt_ptr;
    logic [SW-1:0]    starve_cnt;
    logic [BW-1:0]    burst_cnt;
    logic [N_DEV-1:0] pick_oh, owner_oh;
    logic             pick_any, sat, starved, burst_end, hold;

    dcpu_rr_pick #(.N(N_DEV)) u_pick (
        .req (dev_req),
        .ptr (rr_ptr),
        .gnt (pick_oh),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign owner_oh  = N_DEV'(1) << owner;
    assign sat       = starve_cnt == SW'(STARVE_LIMIT);
    assign starved   = sat && pick_any;
    assign burst_end = burst_cnt == BW'(BURST_MAX);
    assign hold      = dev_req[owner] && dev_lock[owner] && !burst_end;
    // The device granted (or force-released) this cycle is the owner when locked.
    assign nxt_ptr   = IW'((int'(state == LOCKED ? owner : pick_idx) + 1) % N_DEV);
    assign rdata     = ram_rdata;
    assign ram_en    = cpu_gnt || |dev_gnt;

    // Locked: only the owner, except the forced-release cycle which belongs to the CPU.
    always_comb begin
        cpu_gnt = 1'b0;
        dev_gnt = '0;
        if (!RESET) begin
            cpu_gnt = (state == LOCKED) ? burst_end && cpu_req : cpu_req && !starved;
            dev_gnt = (state == LOCKED) ? (hold ? owner_oh : '0)
                                        : ((starved || !cpu_req) ? pick_oh : '0);
        end
    end

    // AND-OR mux keeps the RAM address/data at zero when nothing is granted.
    always_comb begin
        ram_we    = cpu_gnt && cpu_we;
        ram_addr  = cpu_gnt ? cpu_addr : '0;
        ram_wdata = cpu_gnt ? cpu_wdata : '0;
        for (int i = 0; i < N_DEV; i++) begin
            ram_we    = ram_we | (dev_gnt[i] & dev_we[i]);
            ram_addr  = ram_addr | (dev_gnt[i] ? dev_addr[ADDR_W*i +: ADDR_W] : '0);
            ram_wdata = ram_wdata | (dev_gnt[i] ? dev_wdata[DATA_W*i +: DATA_W] : '0);
        end
    end

    always_ff @(posedge CORE_CLK or posedge RESET) begin
        if (RESET) begin
            state      <= ARB;
            owner      <= '0;
            rr_ptr     <= '0;
            starve_cnt <= '0;
            burst_cnt  <= '0;
            cpu_rvalid <= 1'b0;
            dev_rvalid <= '0;
        end else begin
            cpu_rvalid <= cpu_gnt && !cpu_we;
            dev_rvalid <= dev_gnt & ~dev_we;
            rr_ptr     <= (|dev_gnt || (state == LOCKED && burst_end)) ? nxt_ptr : rr_ptr;
            starve_cnt <= (|dev_gnt || !pick_any) ? '0 : (sat ? starve_cnt : starve_cnt + SW'(1));
            if (state == ARB) begin
                if (|dev_gnt && dev_lock[pick_idx]) begin
                    state     <= LOCKED;
                    owner     <= pick_idx;
                    burst_cnt <= BW'(1);
                end
            end else if (hold) begin
                burst_cnt <= burst_cnt + BW'(1);
            end else begin
                state     <= ARB;
                burst_cnt <= '0;
            end
        end
    end

endmodule
